// File: rtl/ws2812_pkg.sv
// Shared types and default 20 MHz timing for the WS2812 output stage of the
// APA102-to-WS2812 bridge.
package ws2812_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } state_t;

  // Default timing in clk cycles at 20 MHz
  localparam int T_BIT_DEF   = 25;    // 1.25 us per data bit
  localparam int T0H_DEF     = 8;     // 0.40 us high for a 0 bit
  localparam int T1H_DEF     = 16;    // 0.80 us high for a 1 bit
  localparam int T_LATCH_DEF = 1600;  // 80 us low to latch the strip

  localparam int PIX_W = 24;

  // Field order matches the wire order: G first, MSB first
  typedef struct packed {
    logic [7:0] g;
    logic [7:0] r;
    logic [7:0] b;
  } grb_t;

endpackage

// File: rtl/ws2812_encoder.sv
// WS2812 NRZ serialiser: takes GRB pixels over valid/ready, shifts them out
// MSB-first with per-bit high times, and inserts the latch low period when a
// frame end has been requested.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | ready for a pixel; starts a latch if one is requested
// SHIFT | sending sr[23]; cyc_cnt walks the bit, bit_cnt walks the pixel
// LATCH | dout held low for T_LATCH cycles, then back to IDLE
module ws2812_encoder
  import ws2812_pkg::*;
#(
  parameter int T_BIT   = T_BIT_DEF,
  parameter int T0H     = T0H_DEF,
  parameter int T1H     = T1H_DEF,
  parameter int T_LATCH = T_LATCH_DEF
) (
  input  logic clk,
  input  logic rst,
  input  grb_t pix_data,
  input  logic pix_valid,
  output logic pix_ready,
  input  logic frame_end,
  output logic dout,
  output logic busy
);

  localparam int CYC_W = $clog2(T_BIT);
  localparam int LAT_W = $clog2(T_LATCH + 1);

  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(T_BIT - 1);
  localparam logic [CYC_W-1:0] HI_ONE   = CYC_W'(T1H);
  localparam logic [CYC_W-1:0] HI_ZERO  = CYC_W'(T0H);
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(T_LATCH - 1);
  localparam logic [4:0]       BIT_LAST = 5'(PIX_W - 1);

  state_t             state, state_n;
  logic [PIX_W-1:0]   sr, sr_n;
  logic [CYC_W-1:0]   cyc_cnt, cyc_n;
  logic [4:0]         bit_cnt, bit_n;
  logic [LAT_W-1:0]   lat_cnt, lat_n;
  logic               latch_pend, pend_n;
  logic               ready_n;
  logic               dout_n;
  logic               take;

  assign take = pix_valid & pix_ready;
  assign busy = (state != IDLE) | latch_pend;

  // Next-state, counter and registered-output decode
  always_comb begin
    state_n = state;
    sr_n    = sr;
    cyc_n   = cyc_cnt;
    bit_n   = bit_cnt;
    lat_n   = lat_cnt;
    // A latch request already being served is not stacked
    pend_n  = latch_pend | (frame_end & (state != LATCH));

    case (state)
      IDLE: begin
        if (take) begin
          sr_n    = pix_data;
          bit_n   = '0;
          cyc_n   = '0;
          state_n = SHIFT;
        end else if (latch_pend || frame_end) begin
          lat_n   = LAT_LOAD;
          state_n = LATCH;
        end
      end
      SHIFT: begin
        if (cyc_cnt != CYC_LAST) begin
          cyc_n = cyc_cnt + 1'b1;
        end else if (bit_cnt != BIT_LAST) begin
          sr_n  = {sr[PIX_W-2:0], 1'b0};
          bit_n = bit_cnt + 5'd1;
          cyc_n = '0;
        end else if (take && !latch_pend) begin
          // Seamless reload: next pixel's first bit follows immediately
          sr_n  = pix_data;
          bit_n = '0;
          cyc_n = '0;
        end else if (latch_pend || frame_end) begin
          lat_n   = LAT_LOAD;
          bit_n   = '0;
          cyc_n   = '0;
          state_n = LATCH;
        end else begin
          bit_n   = '0;
          cyc_n   = '0;
          state_n = IDLE;
        end
      end
      LATCH: begin
        if (lat_cnt == '0) begin
          pend_n  = 1'b0;
          state_n = IDLE;
        end else begin
          lat_n = lat_cnt - 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    // Ready is withheld in the final bit slot when a latch is owed, so a
    // raised ready always means the offered pixel will be taken.
    ready_n = (state_n == IDLE) ||
              ((state_n == SHIFT) && (bit_n == BIT_LAST) &&
               (cyc_n == CYC_LAST) && !pend_n);

    // dout lags the state by one cycle so a transfer edge is still low
    dout_n = (state == SHIFT) && (cyc_cnt < (sr[PIX_W-1] ? HI_ONE : HI_ZERO));
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      sr         <= '0;
      cyc_cnt    <= '0;
      bit_cnt    <= '0;
      lat_cnt    <= '0;
      latch_pend <= 1'b0;
      pix_ready  <= 1'b0;
      dout       <= 1'b0;
    end else begin
      state      <= state_n;
      sr         <= sr_n;
      cyc_cnt    <= cyc_n;
      bit_cnt    <= bit_n;
      lat_cnt    <= lat_n;
      latch_pend <= pend_n;
      pix_ready  <= ready_n;
      dout       <= dout_n;
    end
  end

endmodule

// File: tb/tb_ws2812_encoder.sv
// Directed bench for ws2812_encoder: table of single-pixel frames plus
// hand-written back-to-back, coincident frame_end, idle latch and reset cases.
module tb_ws2812_encoder;

  localparam int T_BIT   = 25;
  localparam int T0H     = 8;
  localparam int T1H     = 16;
  localparam int T_LATCH = 1600;
  localparam int PIX_CYC = 24 * T_BIT;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] pix_data = '0;
  logic        pix_valid = 1'b0;
  logic        pix_ready;
  logic        frame_end = 1'b0;
  logic        dout;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  logic wave [0:2*PIX_CYC-1];
  logic rdy  [0:2*PIX_CYC-1];

  typedef struct {
    logic [23:0] data;
    int          exp_high;
  } vec_t;

  vec_t tbl [5];

  ws2812_encoder dut (
    .clk       (clk),
    .rst       (rst),
    .pix_data  (pix_data),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .frame_end (frame_end),
    .dout      (dout),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Leading-high width of one bit slot; -1 if a high appears after the low
  function automatic int slot_width(input int base);
    int w = 0;
    while (w < T_BIT && wave[base + w] == 1'b1) w++;
    for (int j = w; j < T_BIT; j++)
      if (wave[base + j] != 1'b0) return -1;
    return w;
  endfunction

  task automatic check_slots(input string tag, input logic [23:0] d, input int first_slot);
    for (int b = 0; b < 24; b++)
      chk($sformatf("%s bit%0d width", tag, b),
          slot_width((first_slot + b) * T_BIT), d[23-b] ? T1H : T0H);
  endtask

  // Called at a negedge; leaves the bench at the negedge after the transfer
  task automatic start_pixel(input logic [23:0] d, input logic fe);
    int n = 0;
    while (!pix_ready && n < 4000) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", int'(pix_ready), 1);
    pix_data  = d;
    pix_valid = 1'b1;
    frame_end = fe;
    @(negedge clk);
    pix_valid = 1'b0;
    frame_end = 1'b0;
  endtask

  // Sample n cycles of dout starting with the first data cycle
  task automatic capture(input int n, input logic fe_first, input int drop_at);
    frame_end = fe_first;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      frame_end = 1'b0;
      wave[k] = dout;
      rdy[k]  = pix_ready;
      if (k == drop_at) pix_valid = 1'b0;
    end
  endtask

  // Count busy cycles from the current negedge; flags dout/ready highs
  task automatic measure_latch(output int cnt, output int bad, input int fe_at);
    cnt = 0;
    bad = 0;
    while (busy && cnt < 4000) begin
      if (dout || pix_ready) bad++;
      frame_end = (cnt == fe_at);
      cnt++;
      @(negedge clk);
    end
    frame_end = 1'b0;
  endtask

  task automatic run_frame(input string tag, input logic [23:0] d, input int exp_high);
    int cnt, bad, hi;
    start_pixel(d, 1'b0);
    capture(PIX_CYC, 1'b1, -1);
    check_slots(tag, d, 0);
    hi = 0;
    for (int k = 0; k < PIX_CYC; k++) hi += int'(wave[k]);
    chk({tag, " high_total"}, hi, exp_high);
    measure_latch(cnt, bad, -1);
    chk({tag, " latch_len"}, cnt, T_LATCH);
    chk({tag, " latch_dirty"}, bad, 0);
    chk({tag, " busy_after"}, int'(busy), 0);
    chk({tag, " ready_after"}, int'(pix_ready), 1);
  endtask

  initial begin
    int cnt, bad, early;

    // Hand-computed: high total = ones*16 + zeros*8
    tbl[0] = '{24'hA50000, 224};
    tbl[1] = '{24'h000000, 192};
    tbl[2] = '{24'hFFFFFF, 384};
    tbl[3] = '{24'h5A0F81, 272};
    tbl[4] = '{24'h800001, 208};

    // Reset held, then released
    repeat (3) @(negedge clk);
    chk("rst dout", int'(dout), 0);
    chk("rst ready", int'(pix_ready), 0);
    chk("rst busy", int'(busy), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst ready", int'(pix_ready), 1);
    chk("post_rst dout", int'(dout), 0);
    chk("post_rst busy", int'(busy), 0);

    // Single-pixel frames, frame_end one cycle after the transfer
    for (int i = 0; i < 5; i++)
      run_frame($sformatf("vec%0d", i), tbl[i].data, tbl[i].exp_high);

    // Back-to-back pixels with pix_valid held high
    pix_data  = 24'hFFFFFF;
    pix_valid = 1'b1;
    @(negedge clk);
    pix_data = 24'h000000;
    capture(2 * PIX_CYC, 1'b0, PIX_CYC - 1);
    check_slots("b2b0", 24'hFFFFFF, 0);
    check_slots("b2b1", 24'h000000, 24);
    early = 0;
    for (int k = 0; k < PIX_CYC - 2; k++) early += int'(rdy[k]);
    chk("b2b ready_early", early, 0);
    chk("b2b ready_last_slot", int'(rdy[PIX_CYC-2]), 1);
    chk("b2b busy_after", int'(busy), 0);

    // frame_end together with the IDLE transfer
    start_pixel(24'h000001, 1'b1);
    capture(PIX_CYC, 1'b0, -1);
    check_slots("fe_coinc", 24'h000001, 0);
    early = 0;
    for (int k = 0; k < PIX_CYC; k++) early += int'(rdy[k]);
    chk("fe_coinc ready_during", early, 0);
    measure_latch(cnt, bad, -1);
    chk("fe_coinc latch_len", cnt, T_LATCH);
    chk("fe_coinc latch_dirty", bad, 0);

    // frame_end in IDLE with no pixel; a second pulse mid-latch is ignored
    frame_end = 1'b1;
    @(negedge clk);
    frame_end = 1'b0;
    measure_latch(cnt, bad, 800);
    chk("idle_latch len", cnt, T_LATCH);
    chk("idle_latch dirty", bad, 0);
    chk("idle_latch ready_after", int'(pix_ready), 1);

    // Asynchronous reset in the middle of a pixel
    start_pixel(24'h123456, 1'b0);
    repeat (301) @(negedge clk);
    chk("mid dout_before_rst", int'(dout), 1);
    #2 rst = 1'b1;
    #1;
    chk("mid async dout", int'(dout), 0);
    chk("mid async busy", int'(busy), 0);
    chk("mid async ready", int'(pix_ready), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("mid post_rst ready", int'(pix_ready), 1);
    chk("mid post_rst busy", int'(busy), 0);
    run_frame("recover", 24'h800000, 200);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
